day_7_stream_ctrl: RTL and testbench

Streaming controller for the day 7 beam-splitter puzzle. It accepts the puzzle grid as an ASCII byte stream over a valid/ready handshake and builds one row bitmask at a time. After each completed row it runs a single beam-propagation step and accumulates the split count, so the grid is never stored in memory. It replaces preloaded grid images with an input path suitable for a UART or DMA front end.

---
 rtl/day_7_pkg.sv | 23 ++
 rtl/day_7_beam_step.sv | 29 ++
 rtl/day_7_stream_ctrl.sv | 146 ++++++++++++++
 tb/tb_day_7_stream_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/day_7_pkg.sv
// Shared types and constants for the day 7 beam-splitter stream controller.
package day_7_pkg;

    localparam int unsigned DEF_WIDTH  = 141;
    localparam int unsigned DEF_HEIGHT = 141;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned RES_W      = 32;

    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_SPLIT = 8'h5E;
    localparam logic [7:0] CH_START = 8'h53;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_STEP,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/day_7_beam_step.sv
// One beam-propagation step: splitters under the beam fan out left/right.
module day_7_beam_step
    import day_7_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] beam,
    input  logic [WIDTH-1:0] row,
    output logic [WIDTH-1:0] beam_next,
    output logic [CNT_W-1:0] split_cnt
);

    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] pass;

    assign hit  = beam & row;
    assign pass = beam & ~row;

    // Shifts stay WIDTH bits wide, so edge splits lose their outward half.
    assign beam_next = pass | (hit << 1) | (hit >> 1);

    always_comb begin
        split_cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            split_cnt = split_cnt + CNT_W'(hit[i]);
        end
    end

endmodule

// File: rtl/day_7_stream_ctrl.sv
// Streaming day 7 controller: builds one row from ASCII bytes, then steps the beam.
module day_7_stream_ctrl
    import day_7_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned HEIGHT = DEF_HEIGHT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             done,
    output logic             err,
    output logic [RES_W-1:0] result
);

    localparam int unsigned COL_W = $clog2(WIDTH + 1);
    localparam int unsigned ROW_W = $clog2(HEIGHT + 1);

    state_t             state,   state_n;
    logic [WIDTH-1:0]   row_buf, row_n;
    logic [WIDTH-1:0]   smask,   smask_n;
    logic [WIDTH-1:0]   beam,    beam_n;
    logic [COL_W-1:0]   col,     col_n;
    logic [ROW_W-1:0]   row_idx, row_idx_n;
    logic [RES_W-1:0]   sum,     sum_n;
    logic [RES_W-1:0]   result_n;
    logic [WIDTH-1:0]   step_beam;
    logic [CNT_W-1:0]   step_cnt;

    day_7_beam_step #(.WIDTH(WIDTH)) u_step (
        .beam      (beam),
        .row       (row_buf),
        .beam_next (step_beam),
        .split_cnt (step_cnt)
    );

    always_comb begin
        state_n   = state;
        row_n     = row_buf;
        smask_n   = smask;
        beam_n    = beam;
        col_n     = col;
        row_idx_n = row_idx;
        sum_n     = sum;
        result_n  = result;

        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    row_n     = '0;
                    smask_n   = '0;
                    beam_n    = '0;
                    col_n     = '0;
                    row_idx_n = '0;
                    sum_n     = '0;
                    result_n  = '0;
                    state_n   = ST_FILL;
                end
            end

            ST_FILL: begin
                if (in_valid && in_ready) begin
                    case (in_data)
                        CH_DOT, CH_SPLIT, CH_START: begin
                            if (col == COL_W'(WIDTH)) begin
                                state_n = ST_ERROR;
                            end else begin
                                row_n[col] = (in_data == CH_SPLIT);
                                if (in_data == CH_START) begin
                                    smask_n[col] = 1'b1;
                                end
                                col_n = col + COL_W'(1);
                            end
                        end
                        CH_CR: ;
                        CH_NL: state_n = (col == COL_W'(WIDTH)) ? ST_STEP : ST_ERROR;
                        default: state_n = ST_ERROR;
                    endcase
                end
            end

            ST_STEP: begin
                // Row 0 only seeds the beam from its single S; later rows propagate it.
                if (row_idx == '0) begin
                    if (!$onehot(smask)) begin
                        state_n = ST_ERROR;
                    end else begin
                        beam_n = smask;
                    end
                end else if (smask != '0) begin
                    state_n = ST_ERROR;
                end else begin
                    beam_n = step_beam;
                    sum_n  = sum + RES_W'(step_cnt);
                end

                if (state_n != ST_ERROR) begin
                    row_n     = '0;
                    smask_n   = '0;
                    col_n     = '0;
                    row_idx_n = row_idx + ROW_W'(1);
                    if (row_idx == ROW_W'(HEIGHT - 1)) begin
                        state_n  = ST_DONE;
                        result_n = sum_n;
                    end else begin
                        state_n = ST_FILL;
                    end
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            row_buf  <= '0;
            smask    <= '0;
            beam     <= '0;
            col      <= '0;
            row_idx  <= '0;
            sum      <= '0;
            result   <= '0;
            in_ready <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            row_buf  <= row_n;
            smask    <= smask_n;
            beam     <= beam_n;
            col      <= col_n;
            row_idx  <= row_idx_n;
            sum      <= sum_n;
            result   <= result_n;
            in_ready <= (state_n == ST_FILL);
            done     <= (state_n == ST_DONE);
            err      <= (state_n == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_day_7_stream_ctrl.sv
// Scoreboard bench for day_7_stream_ctrl on a 5x3 grid.
module tb_day_7_stream_ctrl;
    import day_7_pkg::*;

    localparam int unsigned W = 5;
    localparam int unsigned H = 3;

    typedef enum int {K_RST, K_DONE, K_ERR} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] res;
        int          lat;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        done;
    logic        err;
    logic [31:0] result;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   run_id = 0;
    int   start_cyc = 0;
    int   seen_id = 0;
    int   stalls = 0;
    int   wait_cnt = 0;
    bit   abort_run = 0;
    bit   prev_rst = 0;
    bit   prev_done = 0;
    bit   prev_err = 0;

    day_7_stream_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .done     (done),
        .err      (err),
        .result   (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: pops an expectation on every reset, done rise or err rise.
    always @(negedge clk) begin
        exp_t e;
        if (rst && !prev_rst) begin
            if (sb.size() == 0 || sb[0].kind != K_RST) begin
                checks++;
                errors++;
                $display("FAIL unexpected_reset: got reset event expected none");
            end else begin
                e = sb.pop_front();
                chk({e.name, "_in_ready"}, 32'(in_ready), 32'd0);
                chk({e.name, "_done"}, 32'(done), 32'd0);
                chk({e.name, "_err"}, 32'(err), 32'd0);
                chk({e.name, "_result"}, result, 32'd0);
            end
            wait_cnt = 0;
        end else if (!rst) begin
            if ((done && !prev_done) || (err && !prev_err)) begin
                if (sb.size() == 0 || sb[0].kind == K_RST) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_end: got done=%0d err=%0d expected no event", done, err);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_done"}, 32'(done), 32'(e.kind == K_DONE));
                    chk({e.name, "_err"}, 32'(err), 32'(e.kind == K_ERR));
                    chk({e.name, "_result"}, result, e.res);
                    chk({e.name, "_in_ready"}, 32'(in_ready), 32'd0);
                    if (e.kind == K_DONE) begin
                        chk({e.name, "_stalls"}, 32'(stalls), 32'(H));
                        if (e.lat >= 0) chk({e.name, "_latency"}, 32'(cyc - start_cyc), 32'(e.lat));
                    end
                end
                wait_cnt = 0;
            end else if (done && prev_done && in_valid) begin
                chk("done_holds_off_input", 32'(in_ready), 32'd0);
            end
            if (run_id != seen_id) begin
                seen_id = run_id;
                stalls  = 0;
            end else if (!in_ready && !done && !err) begin
                stalls++;
            end
        end
        if (sb.size() != 0) begin
            wait_cnt++;
            if (wait_cnt > 300) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL %s_timeout: got no event expected one within 300 cycles", e.name);
                wait_cnt = 0;
            end
        end else begin
            wait_cnt = 0;
        end
        prev_rst  = rst;
        prev_done = done;
        prev_err  = err;
    end

    task automatic push_exp(input kind_t k, input logic [31:0] res, input int lat, input string nm);
        exp_t e;
        e.kind = k;
        e.res  = res;
        e.lat  = lat;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic start_run();
        start     = 1'b1;
        start_cyc = cyc + 1;
        run_id++;
        @(negedge clk);
        start = 1'b0;
        abort_run = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] c, input bit gaps);
        if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = c;
        for (int k = 0; k < 8 && !in_ready; k++) @(negedge clk);
        if (in_ready) begin
            @(negedge clk);
        end else begin
            abort_run = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input bit gaps);
        for (int i = 0; i < s.len() && !abort_run; i++) put_byte(s[i], gaps);
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
    endtask

    // Gapless done-runs take start cycle + bytes + one STEP per row.
    task automatic run(input string s, input bit gaps, input kind_t k, input logic [31:0] res, input string nm);
        push_exp(k, res, (k == K_DONE && !gaps) ? s.len() + int'(H) : -1, nm);
        start_run();
        send_str(s, gaps);
        drain();
    endtask

    initial begin
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        push_exp(K_RST, 32'd0, -1, "por");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run("..S..\n.....\n..^..\n", 1'b0, K_DONE, 32'd1, "single_split");
        run("..S..\n..^..\n.^.^.\n", 1'b0, K_DONE, 32'd3, "fan_out");

        // Bytes offered while DONE must be refused.
        in_valid = 1'b1;
        in_data  = CH_DOT;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;

        run("S....\n^....\n.....\n", 1'b0, K_DONE, 32'd1, "left_edge");
        run("....S\n....^\n...^.\n", 1'b0, K_DONE, 32'd2, "right_edge");
        run("^.S.^\n..^..\n.....\n", 1'b0, K_DONE, 32'd1, "row0_split_ignored");
        run("..S.\n", 1'b0, K_ERR, 32'd0, "short_row");
        run("..S..\r\n.....\r\n..^..\r\n", 1'b1, K_DONE, 32'd1, "gaps_crlf");
        run("..X", 1'b0, K_ERR, 32'd0, "bad_char");
        run("S.S..\n", 1'b0, K_ERR, 32'd0, "two_starts");
        run("..S..\n..S..\n", 1'b0, K_ERR, 32'd0, "late_start");
        run("......", 1'b0, K_ERR, 32'd0, "long_row");
        run("..S..\n.....\n..^..\n", 1'b0, K_DONE, 32'd1, "after_error");

        // Abort in the middle of row 1, then a clean run.
        start_run();
        send_str("..S..\n..", 1'b0);
        push_exp(K_RST, 32'd0, -1, "mid_run_reset");
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drain();
        run("..S..\n..^..\n.^.^.\n", 1'b0, K_DONE, 32'd3, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
